palette_ram: RTL and testbench
==============================

PALETTE_RAM -- requirements
Module: palette_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, entry width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter OUT_REG, default 1; 0 or 1; adds an output pipeline stage.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port wr_en, input, 1, write strobe.
REQ-007 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-008 SHALL have port wr_be, input, DATA_W/8, per-byte write enable.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have port rd_en, input, 1, read strobe.
REQ-011 SHALL have port rd_addr, input, ADDR_W, read address.
REQ-012 SHALL have port rd_data, output, DATA_W, read data.
REQ-013 SHALL have port rd_valid, output, 1, rd_data holds a result this cycle.
REQ-014 SHALL have port busy, output, 1, clear sweep in progress.

Function
REQ-015 Write SHALL update only the bytes whose wr_be bit is 1, at the edge where wr_en=1 and busy=0.
REQ-016 Read latency SHALL be 1+OUT_REG cycles from the rd_en edge to rd_valid=1, with rd_valid a one-cycle pulse per accepted read.
REQ-017 Back-to-back reads SHALL be accepted every cycle, with results returned in order and no bubbles.
REQ-018 rd_data SHALL hold its last value while rd_valid=0.
REQ-019 On a same-cycle read and write to the same address, the read SHALL return write-first merged data: written bytes new, unwritten bytes old.
REQ-020 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-021 Requests with rd_en or wr_en asserted while busy=1 SHALL be ignored: no memory change and no rd_valid.
REQ-022 Reads already in the output pipeline when busy rises SHALL still complete.

Reset
REQ-023 While rst_n=0: rd_data=0, rd_valid=0, pipeline flushed, and busy=1 if PALETTE_CLEAR_EN is defined, else busy=0.
REQ-024 The memory array SHALL NOT be reset directly; array contents change only through the clear sweep or writes.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep, and the sweep SHALL restart from address 0 after release.

Configuration
REQ-026 With macro PALETTE_CLEAR_EN defined, the block SHALL run the FSM CLEAR -> IDLE.
- CLEAR is entered on reset release.
- CLEAR writes 0 to addresses 0..2**ADDR_W-1 ascending, one per cycle.
- busy=1 throughout CLEAR.
- The FSM moves to IDLE after the last address; busy falls the following cycle.
- Total busy after release: exactly 2**ADDR_W cycles.
- The address counter wraps to 0 on the CLEAR->IDLE transition.
REQ-027 Without PALETTE_CLEAR_EN, there SHALL be no FSM or counter, busy SHALL be tied 0, and array contents after power-up are unspecified.

Structure
REQ-028 A shared package palette_pkg SHALL hold the FSM state enum (CLEAR, IDLE) and the default constants for DATA_W, ADDR_W and OUT_REG.
REQ-029 The storage SHALL be one sub-module palette_ram_core:
- inferred simple dual-port array with a synchronous read;
- byte-enabled write.
Forwarding, the valid pipeline and the clear FSM stay in palette_ram.

Verification
REQ-030 Default params, macro on: release rst_n -> busy=1 for exactly 64 cycles, then reads of addr 0, 31 and 63 return 0x0000 with rd_valid 2 cycles after rd_en.
REQ-031 Write 0xABCD to addr 5 with be=2'b11, then write 0x12xx with be=2'b10 -> read of addr 5 returns 0x12CD.
REQ-032 Same cycle: write 0x5A5A to addr 9 (be=2'b01) and read addr 9 (old 0xFFFF) -> returns 0xFF5A.
REQ-033 OUT_REG=0: reads of addrs 1, 2, 3 on consecutive cycles -> rd_valid high for 3 consecutive cycles starting 1 cycle later, data in order.
REQ-034 Drop rst_n at sweep address 20 -> busy=1 during reset; after release the sweep covers 64 cycles from address 0; a write attempted during busy is lost.
REQ-035 Macro off -> busy stays 0 from reset, and a write at the first post-reset cycle is accepted.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types and default sizes for the palette RAM slice.
// FSM state enum (CLEAR, IDLE) plus DATA_W/ADDR_W/OUT_REG defaults.
package palette_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 6;
  localparam int OUT_REG_DEF = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/palette_ram_if.sv
// Write/read request bus of the palette RAM.
// master drives wr_*/rd_en/rd_addr; slave returns rd_data/rd_valid/busy.
interface palette_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) ();

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W/8-1:0]   wr_be;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/palette_ram_core.sv
// Simple dual-port storage: byte-enabled write, registered read.
// Ports: clk, we/wa/wbe/wd write side, re/ra read side, rq read data.
module palette_ram_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wd,
  input  logic                re,
  input  logic [ADDR_W-1:0]   ra,
  output logic [DATA_W-1:0]   rq
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we && wbe[b]) begin
        mem[wa][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // Read is read-first; the top merges same-cycle writes.
  always_ff @(posedge clk) begin
    if (re) begin
      rq <= mem[ra];
    end
  end

endmodule

// File: rtl/palette_ram.sv
// Palette RAM top: forwarding, read valid pipeline, optional clear.
// Ports: clk, rst_n, bus (slave). Macro PALETTE_CLEAR_EN adds clear.
module palette_ram
  import palette_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OUT_REG = OUT_REG_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  palette_ram_if.slave bus
);

  localparam int NB = DATA_W / 8;

  logic                busy_q;
  logic                wr_acc;
  logic                rd_acc;
  logic                c_we;
  logic [ADDR_W-1:0]   c_wa;
  logic [NB-1:0]       c_wbe;
  logic [DATA_W-1:0]   c_wd;
  logic [DATA_W-1:0]   core_q;
  logic                v1;
  logic                fwd_hit;
  logic [NB-1:0]       fwd_be;
  logic [DATA_W-1:0]   fwd_data;
  logic [DATA_W-1:0]   s1_data;

  assign wr_acc   = bus.wr_en & ~busy_q;
  assign rd_acc   = bus.rd_en & ~busy_q;
  assign bus.busy = busy_q;

`ifdef PALETTE_CLEAR_EN
  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              clearing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy_q   <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          // Counter overflow returns it to 0 on exit.
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // No sweep writes while reset is held.
  assign clearing = (state == CLEAR) & rst_n;
  assign c_we  = clearing | wr_acc;
  assign c_wa  = clearing ? clr_addr : bus.wr_addr;
  assign c_wbe = clearing ? '1 : bus.wr_be;
  assign c_wd  = clearing ? '0 : bus.wr_data;
`else
  assign busy_q = 1'b0;
  assign c_we   = wr_acc;
  assign c_wa   = bus.wr_addr;
  assign c_wbe  = bus.wr_be;
  assign c_wd   = bus.wr_data;
`endif

  palette_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk (clk),
    .we  (c_we),
    .wa  (c_wa),
    .wbe (c_wbe),
    .wd  (c_wd),
    .re  (rd_acc),
    .ra  (bus.rd_addr),
    .rq  (core_q)
  );

  // Capture a colliding write with the read so it can be
  // merged over the read-first core data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_be   <= '0;
      fwd_data <= '0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) begin
        fwd_hit  <= wr_acc & (bus.wr_addr == bus.rd_addr);
        fwd_be   <= bus.wr_be;
        fwd_data <= bus.wr_data;
      end
    end
  end

  always_comb begin
    s1_data = core_q;
    for (int b = 0; b < NB; b++) begin
      if (fwd_hit && fwd_be[b]) begin
        s1_data[8*b +: 8] = fwd_data[8*b +: 8];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] out_q;
      logic              v2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
          v2    <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) begin
            out_q <= s1_data;
          end
        end
      end

      assign bus.rd_data  = out_q;
      assign bus.rd_valid = v2;
    end else begin : g_noreg
      logic seen;

      // Core data is unknown until the first read lands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seen <= 1'b0;
        end else if (v1) begin
          seen <= 1'b1;
        end
      end

      assign bus.rd_data  = (seen | v1) ? s1_data : '0;
      assign bus.rd_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_palette_ram.sv
// Randomized bench for palette_ram, OUT_REG=1 and OUT_REG=0 side by side.
// A memory-array model and per-DUT expected-read queues predict outputs.
module tb_palette_ram;
  import palette_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

`ifdef PALETTE_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  palette_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  palette_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();

  palette_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  palette_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int            n_chk = 0;
  int            n_fail = 0;
  int            busy_left = 0;
  logic [DW-1:0] mem [DEPTH];
  rd_t           q1[$];
  rd_t           q0[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last0 = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)",
               tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic chk_out(input int o);
    logic          v;
    logic [DW-1:0] d;
    logic [DW-1:0] ev;
    bit            due;
    ev  = '0;
    due = 1'b0;
    if (o == 1) begin
      v = b1.rd_valid;
      d = b1.rd_data;
      if (q1.size() > 0 && q1[0].due == edge_n) begin
        due = 1'b1;
        ev  = q1[0].val;
      end
    end else begin
      v = b0.rd_valid;
      d = b0.rd_data;
      if (q0.size() > 0 && q0[0].due == edge_n) begin
        due = 1'b1;
        ev  = q0[0].val;
      end
    end
    chk($sformatf("rd_valid%0d", o), v, due);
    if (due) begin
      chk($sformatf("rd_data%0d", o), d, ev);
      if (o == 1) begin
        last1 = ev;
        void'(q1.pop_front());
      end else begin
        last0 = ev;
        void'(q0.pop_front());
      end
    end else begin
      chk($sformatf("rd_hold%0d", o), d, (o == 1) ? last1 : last0);
    end
  endtask

  task automatic apply(input logic we, input logic [AW-1:0] wa,
                       input logic [NB-1:0] be, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra);
    rd_t e;
    b1.wr_en = we; b1.wr_addr = wa; b1.wr_be = be; b1.wr_data = wd;
    b1.rd_en = re; b1.rd_addr = ra;
    b0.wr_en = we; b0.wr_addr = wa; b0.wr_be = be; b0.wr_data = wd;
    b0.rd_en = re; b0.rd_addr = ra;
    if (busy_left == 0) begin
      if (re) begin
        e.val = mem[ra];
        if (we && wa == ra) e.val = merge(e.val, wd, be);
        e.due = edge_n + 2;
        q1.push_back(e);
        e.due = edge_n + 1;
        q0.push_back(e);
      end
      if (we) mem[wa] = merge(mem[wa], wd, be);
    end
  endtask

  task automatic cyc(input logic we, input logic [AW-1:0] wa,
                     input logic [NB-1:0] be, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra);
    @(negedge clk);
    if (busy_left > 0) busy_left--;
    chk("busy1", b1.busy, busy_left > 0);
    chk("busy0", b0.busy, busy_left > 0);
    chk_out(1);
    chk_out(0);
    apply(we, wa, be, wd, re, ra);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cyc(1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic do_reset(input int n, input logic we,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(negedge clk);
    rst_n = 1'b0;
    busy_left = 0;
    apply(1'b0, '0, '0, '0, 1'b0, '0);
    q1.delete();
    q0.delete();
    last1 = '0;
    last0 = '0;
    repeat (n) begin
      #1;
      chk("rst_valid1", b1.rd_valid, 1'b0);
      chk("rst_valid0", b0.rd_valid, 1'b0);
      chk("rst_data1", b1.rd_data, '0);
      chk("rst_data0", b0.rd_data, '0);
      chk("rst_busy1", b1.busy, CLR);
      chk("rst_busy0", b0.busy, CLR);
      @(negedge clk);
    end
    rst_n = 1'b1;
    if (CLR) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
    apply(we, wa, '1, wd, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    apply(1'b0, '0, '0, '0, 1'b0, '0);

    do_reset(3, 1'b1, '0, 16'hC0DE);
    idle(DEPTH + 1);

    rd(AW'(0));
`ifdef PALETTE_CLEAR_EN
    rd(AW'(31));
    rd(AW'(63));
`endif
    idle(3);

    for (int a = 1; a < DEPTH; a++)
      cyc(1'b1, AW'(a), '1, DW'($urandom), 1'b0, '0);

    cyc(1'b1, AW'(5), 2'b11, 16'hABCD, 1'b0, '0);
    cyc(1'b1, AW'(5), 2'b10, {8'h12, 8'($urandom)}, 1'b0, '0);
    rd(AW'(5));

    cyc(1'b1, AW'(9), 2'b11, 16'hFFFF, 1'b0, '0);
    cyc(1'b1, AW'(9), 2'b01, 16'h5A5A, 1'b1, AW'(9));

    cyc(1'b1, AW'(12), 2'b11, 16'h1357, 1'b0, '0);
    rd(AW'(12));

    rd(AW'(1));
    rd(AW'(2));
    rd(AW'(3));
    idle(3);

    for (int i = 0; i < 500; i++) begin
      logic          we;
      logic          re;
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      we = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 9) < 7);
      wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                        : AW'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                        : AW'($urandom);
      cyc(we, wa, NB'($urandom), DW'($urandom), re, ra);
    end
    idle(3);

    do_reset(2, 1'b0, '0, '0);
    cyc(1'b1, AW'(7), '1, 16'h1234, 1'b0, '0);
    rd(AW'(3));
    idle(17);
    do_reset(3, 1'b1, AW'(7), 16'hBEEF);
    idle(DEPTH + 1);
    rd(AW'(7));
    rd(AW'(20));
    rd(AW'(0));
    idle(4);

    chk("drain", q1.size() + q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
